// File: rtl/mem_access_seq_if.sv
// rtl/mem_access_seq_if.sv - request-side and pseudo-MMU-side signals of the load/store sequencer
interface mem_access_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_i;
  logic                  we_i;
  logic [2:0]            funct3_i;
  logic [DATA_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  fault_o;
  logic [DATA_WIDTH-1:0] fault_addr_o;
  logic [DATA_WIDTH-1:0] mdr_o;
  logic [DATA_WIDTH-1:0] pmmu_ir_o;
  logic [DATA_WIDTH-1:0] pmmu_addr_o;
  logic [DATA_WIDTH-1:0] pmmu_wd_o;
  logic                  pmmu_mrd_o;
  logic                  pmmu_mwr_o;
  logic [DATA_WIDTH-1:0] pmmu_rd_i;
  logic                  pmmu_rdy_i;

  modport master (
    output req_i, we_i, funct3_i, addr_i, wdata_i, pmmu_rd_i, pmmu_rdy_i,
    input  busy_o, done_o, fault_o, fault_addr_o, mdr_o,
    input  pmmu_ir_o, pmmu_addr_o, pmmu_wd_o, pmmu_mrd_o, pmmu_mwr_o
  );

  modport slave (
    input  req_i, we_i, funct3_i, addr_i, wdata_i, pmmu_rd_i, pmmu_rdy_i,
    output busy_o, done_o, fault_o, fault_addr_o, mdr_o,
    output pmmu_ir_o, pmmu_addr_o, pmmu_wd_o, pmmu_mrd_o, pmmu_mwr_o
  );
endinterface

// File: rtl/mem_access_seq.sv
// rtl/mem_access_seq.sv - multi-cycle load/store sequencer driving the pseudo-MMU strobes
// Optional misaligned/illegal access trap: define MISALIGN_TRAP_EN.
module mem_access_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk_i,
  input  logic           reset_i,
  mem_access_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_RMW_RD,
    S_WR,
    S_DONE,
    S_FAULT
  } state_t;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_mrd_n;
  logic                  r_mwr_n;
  logic [2:0]            r_funct3;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_mdr;
  logic [DATA_WIDTH-1:0] w_ir;
  logic [1:0]            w_size;
  logic                  w_is_word;
  logic                  w_trap;

  assign w_size    = bus.funct3_i[1:0];
  assign w_is_word = w_size[1];

`ifdef MISALIGN_TRAP_EN
  logic                  r_fault;
  logic [DATA_WIDTH-1:0] r_fault_addr;

  assign w_trap = (w_size == 2'b11)
               || ((w_size == 2'b01) && bus.addr_i[0])
               || ((w_size == 2'b10) && (bus.addr_i[1:0] != 2'b00));
  assign bus.fault_o      = r_fault;
  assign bus.fault_addr_o = r_fault_addr;
`else
  // Without the trap, size 11 falls through to the word path.
  assign w_trap           = 1'b0;
  assign bus.fault_o      = 1'b0;
  assign bus.fault_addr_o = '0;
`endif

  always_comb begin
    w_ir         = '0;
    w_ir[14:12]  = r_funct3;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mrd_n  <= 1'b1;
      r_mwr_n  <= 1'b1;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_mdr    <= '0;
`ifdef MISALIGN_TRAP_EN
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      r_fault <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (bus.req_i) begin
            r_funct3 <= bus.funct3_i;
            r_addr   <= bus.addr_i;
            r_wdata  <= bus.wdata_i;
            r_busy   <= 1'b1;
            if (w_trap) begin
              r_state <= S_FAULT;
`ifdef MISALIGN_TRAP_EN
              r_fault      <= 1'b1;
              r_fault_addr <= bus.addr_i;
`endif
            end else if (!bus.we_i) begin
              r_state <= S_RD_ADDR;
              r_mrd_n <= 1'b0;
            end else if (w_is_word) begin
              r_state <= S_WR;
              r_mwr_n <= 1'b0;
            end else begin
              // Sub-word store reads the word first so the MMU can merge lanes.
              r_state <= S_RMW_RD;
              r_mrd_n <= 1'b0;
            end
          end
        end
        S_RD_ADDR: begin
          if (bus.pmmu_rdy_i) r_state <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (bus.pmmu_rdy_i) begin
            r_mdr   <= bus.pmmu_rd_i;
            r_state <= S_DONE;
            r_mrd_n <= 1'b1;
            r_done  <= 1'b1;
          end
        end
        S_RMW_RD: begin
          if (bus.pmmu_rdy_i) begin
            r_state <= S_WR;
            r_mrd_n <= 1'b1;
            r_mwr_n <= 1'b0;
          end
        end
        S_WR: begin
          if (bus.pmmu_rdy_i) begin
            r_state <= S_DONE;
            r_mwr_n <= 1'b1;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        S_FAULT: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_mrd_n <= 1'b1;
          r_mwr_n <= 1'b1;
        end
      endcase
    end
  end

  assign bus.busy_o      = r_busy;
  assign bus.done_o      = r_done;
  assign bus.mdr_o       = r_mdr;
  assign bus.pmmu_ir_o   = w_ir;
  assign bus.pmmu_addr_o = r_addr;
  assign bus.pmmu_wd_o   = r_wdata;
  assign bus.pmmu_mrd_o  = r_mrd_n;
  assign bus.pmmu_mwr_o  = r_mwr_n;

endmodule

// File: tb/tb_mem_access_seq.sv
// tb/tb_mem_access_seq.sv - directed bench for mem_access_seq with a small pseudo-MMU model
module tb_mem_access_seq;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mem_access_seq_if #(.DATA_WIDTH(32)) bus ();

  mem_access_seq #(.DATA_WIDTH(32)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:15];
  logic        pl_we;
  logic [3:0]  pl_idx;
  logic [31:0] pl_val;
  int          mwr_low_cnt;
  int          done_cnt;

  function automatic logic [31:0] mmu_read(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      2'b00:   return f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] mmu_merge(input logic [31:0] word, input logic [31:0] wd,
                                            input logic [2:0] f3, input logic [1:0] lane);
    logic [31:0] w;
    w = word;
    case (f3[1:0])
      2'b00:   w[8*lane +: 8] = wd[7:0];
      2'b01:   if (lane[1]) w[31:16] = wd[15:0]; else w[15:0] = wd[15:0];
      default: w = wd;
    endcase
    return w;
  endfunction

  assign bus.pmmu_rd_i = mmu_read(mem[bus.pmmu_addr_o[5:2]], bus.pmmu_ir_o[14:12],
                                  bus.pmmu_addr_o[1:0]);

  always @(posedge clk) begin
    if (pl_we) mem[pl_idx] <= pl_val;
    else if (!bus.pmmu_mwr_o && bus.pmmu_rdy_i)
      mem[bus.pmmu_addr_o[5:2]] <= mmu_merge(mem[bus.pmmu_addr_o[5:2]], bus.pmmu_wd_o,
                                             bus.pmmu_ir_o[14:12], bus.pmmu_addr_o[1:0]);
    if (!bus.pmmu_mwr_o) mwr_low_cnt <= mwr_low_cnt + 1;
    if (bus.done_o) done_cnt <= done_cnt + 1;
  end

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_we = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Presents a one-cycle request; returns at the negedge of cycle 1.
  task automatic start(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = we; bus.funct3_i = f3; bus.addr_i = a; bus.wdata_i = wd;
    @(negedge clk);
    bus.req_i = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy_o, bus.done_o, bus.fault_o} !== 3'b000) begin
      errors++; $display("FAIL rst_flags actual=%b required=000", {bus.busy_o, bus.done_o, bus.fault_o});
    end
    checks++;
    if ({bus.pmmu_mrd_o, bus.pmmu_mwr_o} !== 2'b11) begin
      errors++; $display("FAIL rst_strobes actual=%b required=11", {bus.pmmu_mrd_o, bus.pmmu_mwr_o});
    end
    checks++;
    if ((bus.mdr_o | bus.fault_addr_o | bus.pmmu_addr_o | bus.pmmu_wd_o | bus.pmmu_ir_o) !== 32'h0) begin
      errors++; $display("FAIL rst_regs mdr=%h fa=%h addr=%h wd=%h ir=%h required=0", bus.mdr_o,
                         bus.fault_addr_o, bus.pmmu_addr_o, bus.pmmu_wd_o, bus.pmmu_ir_o);
    end
    reset = 1'b0;
  endtask

  task automatic test_word_load;
    int m0;
    preload(4'd1, 32'hDEADBEEF);
    m0 = mwr_low_cnt;
    start(1'b0, 3'b010, 32'h4, 32'h0);
    checks++;
    if ({bus.busy_o, bus.pmmu_mrd_o, bus.done_o} !== 3'b100 || bus.pmmu_ir_o !== 32'h2000) begin
      errors++; $display("FAIL wl_c1 busy/mrd/done=%b ir=%h required=100 ir=00002000",
                         {bus.busy_o, bus.pmmu_mrd_o, bus.done_o}, bus.pmmu_ir_o);
    end
    @(negedge clk);
    checks++;
    if (bus.done_o !== 1'b0) begin errors++; $display("FAIL wl_c2_done actual=%b required=0", bus.done_o); end
    @(negedge clk);
    checks++;
    if (bus.done_o !== 1'b1 || bus.mdr_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wl_c3 done=%b mdr=%h required done=1 mdr=deadbeef", bus.done_o, bus.mdr_o);
    end
    @(negedge clk);
    checks++;
    if ({bus.busy_o, bus.done_o, bus.pmmu_mrd_o} !== 3'b001 || mwr_low_cnt != m0) begin
      errors++; $display("FAIL wl_c4 busy/done/mrd=%b mwr_low=%0d required=001 mwr_low=0",
                         {bus.busy_o, bus.done_o, bus.pmmu_mrd_o}, mwr_low_cnt - m0);
    end
  endtask

  task automatic test_byte_load(input logic [2:0] f3, input logic [31:0] exp);
    start(1'b0, f3, 32'h7, 32'h0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done_o) break;
    end
    checks++;
    if (bus.done_o !== 1'b1 || bus.mdr_o !== exp) begin
      errors++; $display("FAIL bl_f3_%0d done=%b mdr=%h required done=1 mdr=%h", f3, bus.done_o, bus.mdr_o, exp);
    end
  endtask

  task automatic test_subword_store;
    int m0;
    preload(4'd0, 32'h11223344);
    m0 = mwr_low_cnt;
    start(1'b1, 3'b000, 32'h1, 32'h000000AB);
    checks++;
    if ({bus.pmmu_mrd_o, bus.pmmu_mwr_o} !== 2'b01) begin
      errors++; $display("FAIL rmw_c1 mrd/mwr=%b required=01", {bus.pmmu_mrd_o, bus.pmmu_mwr_o});
    end
    @(negedge clk);
    checks++;
    if ({bus.pmmu_mrd_o, bus.pmmu_mwr_o} !== 2'b10 || bus.pmmu_addr_o !== 32'h1 || bus.pmmu_wd_o !== 32'hAB) begin
      errors++; $display("FAIL rmw_c2 mrd/mwr=%b addr=%h wd=%h required=10 addr=1 wd=ab",
                         {bus.pmmu_mrd_o, bus.pmmu_mwr_o}, bus.pmmu_addr_o, bus.pmmu_wd_o);
    end
    @(negedge clk);
    checks++;
    if (bus.done_o !== 1'b1 || mem[0] !== 32'h1122AB44 || mwr_low_cnt - m0 != 1 || bus.mdr_o !== 32'hDE) begin
      errors++; $display("FAIL rmw_c3 done=%b mem0=%h mwr_low=%0d mdr=%h required 1 1122ab44 1 000000de",
                         bus.done_o, mem[0], mwr_low_cnt - m0, bus.mdr_o);
    end
    start(1'b0, 3'b010, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.done_o !== 1'b1 || bus.mdr_o !== 32'h1122AB44) begin
      errors++; $display("FAIL rmw_readback done=%b mdr=%h required done=1 mdr=1122ab44", bus.done_o, bus.mdr_o);
    end
  endtask

  task automatic test_word_store;
    start(1'b1, 3'b010, 32'h8, 32'hCAFEF00D);
    checks++;
    if ({bus.pmmu_mrd_o, bus.pmmu_mwr_o} !== 2'b10) begin
      errors++; $display("FAIL ws_c1 mrd/mwr=%b required=10", {bus.pmmu_mrd_o, bus.pmmu_mwr_o});
    end
    @(negedge clk);
    checks++;
    if (bus.done_o !== 1'b1 || bus.pmmu_mwr_o !== 1'b1 || mem[2] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL ws_c2 done=%b mwr=%b mem2=%h required 1 1 cafef00d", bus.done_o, bus.pmmu_mwr_o, mem[2]);
    end
  endtask

  task automatic test_stall;
    int m0;
    m0 = mwr_low_cnt;
    bus.pmmu_rdy_i = 1'b0;
    start(1'b0, 3'b010, 32'h4, 32'h0);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      if (cyc <= 5) begin
        checks++;
        if (bus.pmmu_mrd_o !== 1'b0 || bus.pmmu_addr_o !== 32'h4 || bus.done_o !== 1'b0) begin
          errors++; $display("FAIL stall_c%0d mrd=%b addr=%h done=%b required 0 4 0", cyc, bus.pmmu_mrd_o,
                             bus.pmmu_addr_o, bus.done_o);
        end
      end else begin
        checks++;
        if (bus.done_o !== 1'b1 || bus.mdr_o !== 32'hDEADBEEF || mwr_low_cnt != m0) begin
          errors++; $display("FAIL stall_c6 done=%b mdr=%h mwr_low=%0d required 1 deadbeef 0", bus.done_o,
                             bus.mdr_o, mwr_low_cnt - m0);
        end
      end
      if (cyc == 2) begin
        bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h20; bus.funct3_i = 3'b010;
      end
      if (cyc == 3) bus.req_i = 1'b0;
      if (cyc == 4) bus.pmmu_rdy_i = 1'b1;
      if (cyc < 6) @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.pmmu_addr_o !== 32'h4) begin
      errors++; $display("FAIL stall_after busy=%b addr=%h required 0 4", bus.busy_o, bus.pmmu_addr_o);
    end
  endtask

  task automatic test_misalign;
    start(1'b0, 3'b001, 32'h3, 32'h0);
`ifdef MISALIGN_TRAP_EN
    checks++;
    if (bus.fault_o !== 1'b1 || bus.fault_addr_o !== 32'h3 || {bus.pmmu_mrd_o, bus.pmmu_mwr_o} !== 2'b11
        || bus.done_o !== 1'b0) begin
      errors++; $display("FAIL mis_c1 fault=%b fa=%h strobes=%b done=%b required 1 3 11 0", bus.fault_o,
                         bus.fault_addr_o, {bus.pmmu_mrd_o, bus.pmmu_mwr_o}, bus.done_o);
    end
    @(negedge clk);
    checks++;
    if (bus.fault_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.mdr_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL mis_c2 fault=%b busy=%b mdr=%h required 0 0 deadbeef", bus.fault_o, bus.busy_o, bus.mdr_o);
    end
`else
    checks++;
    if (bus.fault_o !== 1'b0 || bus.pmmu_mrd_o !== 1'b0) begin
      errors++; $display("FAIL mis_c1 fault=%b mrd=%b required 0 0", bus.fault_o, bus.pmmu_mrd_o);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.done_o !== 1'b1 || bus.mdr_o !== 32'h00001122 || bus.fault_addr_o !== 32'h0) begin
      errors++; $display("FAIL mis_c3 done=%b mdr=%h fa=%h required 1 00001122 0", bus.done_o, bus.mdr_o, bus.fault_addr_o);
    end
`endif
  endtask

  task automatic test_back_to_back;
    int m0;
    m0 = mwr_low_cnt;
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.funct3_i = 3'b010; bus.addr_i = 32'hC; bus.wdata_i = 32'h55;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.done_o !== 1'b1) begin errors++; $display("FAIL b2b_c2_done actual=%b required=1", bus.done_o); end
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      errors++; $display("FAIL b2b_c3_idle busy=%b done=%b required 0 0", bus.busy_o, bus.done_o);
    end
    @(negedge clk);
    checks++;
    if (bus.pmmu_mwr_o !== 1'b0) begin errors++; $display("FAIL b2b_c4_mwr actual=%b required=0", bus.pmmu_mwr_o); end
    bus.req_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.done_o !== 1'b1 || mwr_low_cnt - m0 != 2 || mem[3] !== 32'h55) begin
      errors++; $display("FAIL b2b_c5 done=%b mwr_low=%0d mem3=%h required 1 2 00000055", bus.done_o,
                         mwr_low_cnt - m0, mem[3]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_store;
    int m0;
    int d0;
    preload(4'd3, 32'hA5A5A5A5);
    m0 = mwr_low_cnt;
    d0 = done_cnt;
    start(1'b1, 3'b000, 32'hC, 32'h77);
    checks++;
    if (bus.pmmu_mrd_o !== 1'b0) begin errors++; $display("FAIL rms_c1_mrd actual=%b required=0", bus.pmmu_mrd_o); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({bus.busy_o, bus.done_o, bus.fault_o, bus.pmmu_mrd_o, bus.pmmu_mwr_o} !== 5'b00011
        || (bus.mdr_o | bus.pmmu_addr_o | bus.pmmu_wd_o | bus.pmmu_ir_o | bus.fault_addr_o) !== 32'h0) begin
      errors++; $display("FAIL rms_c2 flags=%b mdr=%h addr=%h wd=%h ir=%h required 00011 and zeros",
                         {bus.busy_o, bus.done_o, bus.fault_o, bus.pmmu_mrd_o, bus.pmmu_mwr_o},
                         bus.mdr_o, bus.pmmu_addr_o, bus.pmmu_wd_o, bus.pmmu_ir_o);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (mwr_low_cnt != m0 || done_cnt != d0 || mem[3] !== 32'hA5A5A5A5 || bus.busy_o !== 1'b0) begin
      errors++; $display("FAIL rms_after mwr_low=%0d done=%0d mem3=%h busy=%b required 0 0 a5a5a5a5 0",
                         mwr_low_cnt - m0, done_cnt - d0, mem[3], bus.busy_o);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    mwr_low_cnt = 0; done_cnt = 0;
    pl_we = 1'b0; pl_idx = '0; pl_val = '0;
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.funct3_i = '0; bus.addr_i = '0; bus.wdata_i = '0;
    bus.pmmu_rdy_i = 1'b1;
    reset = 1'b1;
    test_reset();
    test_word_load();
    test_byte_load(3'b000, 32'hFFFFFFDE);
    test_byte_load(3'b100, 32'h000000DE);
    @(negedge clk);
    test_subword_store();
    @(negedge clk);
    test_word_store();
    @(negedge clk);
    test_stall();
    test_misalign();
    @(negedge clk);
    test_back_to_back();
    test_reset_mid_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

Multi-cycle load/store sequencer between the control matrix/datapath and the pseudo-MMU. It accepts one memory request at a time, drives the MMU's active-low read/write strobes over the required cycles, and inserts a read phase before sub-word stores so the MMU merges against valid word data. Load results are captured into a memory data register (MDR). Misaligned accesses are optionally trapped.

## Interface
- DATA_WIDTH, 32, datapath and memory word width
- clk_i  in  1  pos-edge clock
- reset_i  in  1  synchronous, active-high reset
- req_i  in  1  request; sampled only in IDLE
- we_i  in  1  1 = store, 0 = load; sampled with req_i
- funct3_i  in  3  RISC-V load/store funct3; sampled with req_i
- addr_i  in  DATA_WIDTH  byte address; sampled with req_i
- wdata_i  in  DATA_WIDTH  store data; sampled with req_i
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse on completion
- fault_o  out  1  one-cycle pulse on misaligned or illegal access
- fault_addr_o  out  DATA_WIDTH  address of the last faulting request
- mdr_o  out  DATA_WIDTH  registered load result
- pmmu_ir_o  out  DATA_WIDTH  funct3 placed at [14:12], all other bits 0
- pmmu_addr_o  out  DATA_WIDTH  latched request address
- pmmu_wd_o  out  DATA_WIDTH  latched store data
- pmmu_mrd_o  out  1  MMU read strobe, active low
- pmmu_mwr_o  out  1  MMU write strobe, active low
- pmmu_rd_i  in  DATA_WIDTH  MMU read data (already sign/zero extended)
- pmmu_rdy_i  in  1  MMU ready, active high

## Operation
- Sampling. In IDLE with req_i=1, the block latches we_i, funct3_i, addr_i and wdata_i into internal registers. It then leaves IDLE on the same edge.
- Size. Size comes from funct3[1:0]: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- Strobes. All MMU-side outputs are Moore decodes of state and latched registers.
  - pmmu_mrd_o=0 in RD_ADDR, RD_DATA and RMW_RD.
  - pmmu_mwr_o=0 in WR only.
  - Both strobes are 1 in every other state.
- Next state from IDLE on req_i=1:
  - FAULT if the access is misaligned or illegal (see Configuration).
  - RD_ADDR for a load.
  - WR for a word store.
  - RMW_RD for a byte or halfword store.
- State transitions:
  - RD_ADDR → RD_DATA when pmmu_rdy_i=1; otherwise stay.
  - RD_DATA: when pmmu_rdy_i=1, mdr ← pmmu_rd_i and → DONE; otherwise stay with mrd held low.
  - RMW_RD → WR when pmmu_rdy_i=1. This cycle makes BRAM present the target word for the MMU's merge.
  - WR → DONE when pmmu_rdy_i=1. This is exactly one write-enabled edge.
  - DONE: done_o=1, → IDLE.
  - FAULT: fault_o=1, fault_addr_o ← latched addr, → IDLE. No strobe is asserted for a faulting request.
- req_i outside IDLE is ignored; no queueing. A request held high through DONE is re-accepted in the following IDLE cycle.
- mdr_o changes only on a load completion, faults and stores leave it unchanged.

## Timing
- Reset values:
  - busy_o, done_o, fault_o = 0
  - mdr_o, fault_addr_o, pmmu_addr_o, pmmu_wd_o, pmmu_ir_o = 0
  - pmmu_mrd_o = pmmu_mwr_o = 1
  - state = IDLE
- Latency below counts the req_i sample edge as cycle 0, with pmmu_rdy_i held at 1:
  - load: done_o in cycle 3, mdr_o valid from cycle 3
  - word store: write edge at end of cycle 1, done_o in cycle 2
  - sub-word store: RMW_RD in cycle 1, write edge at end of cycle 2, done_o in cycle 3
  - fault: fault_o in cycle 1
- Each cycle of pmmu_rdy_i=0 in a waiting state adds one cycle. Address, data and strobes stay stable throughout the stall.
- Reset mid-operation: the next edge forces IDLE and deasserts both strobes. No write edge occurs after the reset edge, and no done or fault pulse is produced.
- done_o and fault_o never assert in the same cycle. Either one is always followed by at least one IDLE cycle.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A halfword access with addr[0]≠0 goes to FAULT.
  - A word access with addr[1:0]≠0 goes to FAULT.
  - funct3[1:0]=11 goes to FAULT.
- MISALIGN_TRAP_EN undefined:
  - No alignment check; FAULT is unreachable.
  - fault_o and fault_addr_o are tied to 0.
  - funct3[1:0]=11 is treated as a word access.
  - The MMU's in-word lane selection applies to the latched address as given.

## Test plan
- Word load: memory word 1 = 0xDEADBEEF, req load funct3=010 addr=0x4 → done_o in cycle 3, mdr_o=0xDEADBEEF, pmmu_mwr_o never 0.
- Signed byte load: req funct3=000 addr=0x7 on word 0xDEADBEEF → mdr_o=0xFFFFFFDE. Same access with funct3=100 → mdr_o=0x000000DE.
- Sub-word store read-modify-write: word 0 = 0x11223344, store byte 0xAB (funct3=000) to addr=0x1 → mrd low in cycle 1, one mwr-low cycle in cycle 2, done_o in cycle 3. A follow-up word read returns 0x1122AB44.
- Ready stall: pmmu_rdy_i=0 for 3 cycles during RD_ADDR → done_o delayed to cycle 6, addr and mrd stable throughout, req_i pulses while busy ignored.
- Misalignment: with MISALIGN_TRAP_EN, halfword load at addr=0x3 → fault_o in cycle 1, fault_addr_o=0x3, no strobe asserted, mdr_o unchanged.
- Reset mid-store: assert reset_i in cycle 1 (RMW_RD) → IDLE next edge, mwr stays 1, memory word unchanged, all outputs at reset values.
